// File: rtl/axi_bresp_buffer.sv
// AXI B-channel buffer: DEPTH-entry in-order FIFO, 1-cycle min latency, S_BREADY registered (drops when full).
// Optional macro AXI_BRESP_ERR_CNT_EN adds a saturating SLVERR/DECERR pop counter with err_clr.
module axi_bresp_buffer #(
   parameter int DEPTH = 4,
   parameter int ID_W  = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic             S_BVALID,
   output logic             S_BREADY,
   input  logic [1:0]       S_BRESP,
   input  logic [ID_W-1:0]  S_BID,
   output logic             M_BVALID,
   input  logic             M_BREADY,
   output logic [1:0]       M_BRESP,
   output logic [ID_W-1:0]  M_BID,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
`ifdef AXI_BRESP_ERR_CNT_EN
   ,
   input  logic             err_clr,
   output logic [7:0]       err_count
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [1:0]      resp;
      logic [ID_W-1:0] id;
   } ent_t;

   ent_t             mem [DEPTH];
   ent_t             head;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             s_rdy;
   logic             push;
   logic             pop;

   assign push     = S_BVALID & s_rdy;
   assign pop      = M_BVALID & M_BREADY;
   assign empty    = (cnt == '0);
   assign full     = (cnt == CNT_W'(DEPTH));
   assign M_BVALID = !empty;
   assign head     = mem[rd_ptr];
   assign M_BRESP  = empty ? 2'b00 : head.resp;
   assign M_BID    = empty ? '0 : head.id;
   assign count    = cnt;
   assign S_BREADY = s_rdy;

   always_comb begin
      cnt_nxt = cnt;
      case ({push, pop})
         2'b10:   cnt_nxt = cnt + 1'b1;
         2'b01:   cnt_nxt = cnt - 1'b1;
         default: cnt_nxt = cnt;
      endcase
   end

   // Ready looks at the post-edge occupancy so a pop at full reopens the slave side next cycle.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         s_rdy  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt   <= cnt_nxt;
         s_rdy <= (cnt_nxt != CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= '{resp: S_BRESP, id: S_BID};
      end
   end

`ifdef AXI_BRESP_ERR_CNT_EN
   // Clear wins over a same-edge error pop; count sticks at 255.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (pop && M_BRESP[1] && (err_count != 8'hFF)) begin
         err_count <= err_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_axi_bresp_buffer.sv
// Bench for axi_bresp_buffer: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_axi_bresp_buffer;
   localparam int DEPTH = 4;
   localparam int ID_W  = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             ACLK = 1'b0;
   logic             ARESETn = 1'b0;
   logic             S_BVALID = 1'b0;
   logic             S_BREADY;
   logic [1:0]       S_BRESP = 2'b00;
   logic [ID_W-1:0]  S_BID = '0;
   logic             M_BVALID;
   logic             M_BREADY = 1'b0;
   logic [1:0]       M_BRESP;
   logic [ID_W-1:0]  M_BID;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
`ifdef AXI_BRESP_ERR_CNT_EN
   logic             err_clr = 1'b0;
   logic [7:0]       err_count;
`endif

   axi_bresp_buffer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BRESP(S_BRESP), .S_BID(S_BID),
      .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP), .M_BID(M_BID),
      .count(count), .full(full), .empty(empty)
`ifdef AXI_BRESP_ERR_CNT_EN
      , .err_clr(err_clr), .err_count(err_count)
`endif
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [1:0]      resp;
      logic [ID_W-1:0] id;
   } ent_t;

   ent_t q[$];
   int   popped[$];
   logic m_srdy = 1'b0;
   int   m_err = 0;
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue; ready is "not full after this edge".
   always @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         q.delete();
         m_srdy = 1'b0;
         m_err  = 0;
      end else begin
         bit do_push, do_pop;
         ent_t e;
         do_push = S_BVALID && m_srdy;
         do_pop  = M_BREADY && (q.size() > 0);
         if (do_pop) begin
            e = q.pop_front();
            popped.push_back(int'(e.id));
`ifdef AXI_BRESP_ERR_CNT_EN
            if (!err_clr && e.resp[1] && m_err < 255) m_err++;
`endif
         end
`ifdef AXI_BRESP_ERR_CNT_EN
         if (err_clr) m_err = 0;
`endif
         if (do_push) q.push_back('{resp: S_BRESP, id: S_BID});
         m_srdy = (q.size() != DEPTH);
      end
   end

   always @(negedge ACLK) begin
      chk("m_bvalid", M_BVALID, q.size() > 0);
      chk("m_bresp", M_BRESP, q.size() > 0 ? q[0].resp : 2'b00);
      chk("m_bid", M_BID, q.size() > 0 ? q[0].id : '0);
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("s_bready", S_BREADY, m_srdy);
      chk("count_le_depth", count <= DEPTH, 1);
`ifdef AXI_BRESP_ERR_CNT_EN
      chk("err_count", err_count, m_err);
`endif
   end

   task automatic cyc();
      @(posedge ACLK);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      S_BVALID = 1'b0;
      M_BREADY = 1'b1;
      while (!empty && n < 20) begin
         cyc();
         n++;
      end
      M_BREADY = 1'b0;
      chk("drain_done", empty, 1);
   endtask

   initial begin
      int next_id, n;
      bit acc;

      // Reset state
      repeat (3) cyc();
      chk("rst_bvalid", M_BVALID, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_sready", S_BREADY, 0);
      ARESETn = 1'b1;
      #2 chk("sready_before_edge", S_BREADY, 0);
      cyc();
      chk("sready_after_edge", S_BREADY, 1);

      // Single beat
      S_BVALID = 1'b1; S_BRESP = 2'b00; S_BID = 4'd3; M_BREADY = 1'b1;
      cyc();
      S_BVALID = 1'b0;
      chk("single_bvalid", M_BVALID, 1);
      chk("single_bid", M_BID, 3);
      cyc();
      M_BREADY = 1'b0;
      chk("single_empty", empty, 1);

      // Fill and backpressure
      popped.delete();
      for (int i = 1; i <= 4; i++) begin
         S_BVALID = 1'b1; S_BID = ID_W'(i); S_BRESP = 2'(i);
         cyc();
      end
      chk("fill_count", count, 4);
      chk("fill_full", full, 1);
      chk("fill_sready", S_BREADY, 0);
      S_BID = 4'd5;
      cyc();
      S_BVALID = 1'b0;
      chk("fifth_rejected", count, 4);
      chk("head_bid1", M_BID, 1);
      M_BREADY = 1'b1;
      cyc();
      M_BREADY = 1'b0;
      chk("pop1_count", count, 3);
      chk("pop1_sready", S_BREADY, 1);
      chk("pop1_id", popped.size() > 0 ? popped[0] : -1, 1);
      drain();

      // Simultaneous push/pop at count 2
      for (int i = 6; i <= 7; i++) begin
         S_BVALID = 1'b1; S_BID = ID_W'(i);
         cyc();
      end
      chk("sim_pre_count", count, 2);
      S_BID = 4'd8; M_BREADY = 1'b1;
      cyc();
      S_BVALID = 1'b0; M_BREADY = 1'b0;
      chk("sim_count", count, 2);
      chk("sim_head", M_BID, 7);
      drain();

      // Wrap and ordering with toggling ready
      popped.delete();
      next_id = 0;
      n = 0;
      while (!(next_id == 10 && empty) && n < 100) begin
         S_BVALID = (next_id < 10);
         S_BID = ID_W'(next_id);
         S_BRESP = 2'b01;
         M_BREADY = ~M_BREADY;
         acc = S_BVALID && S_BREADY;
         cyc();
         if (acc) next_id++;
         n++;
      end
      S_BVALID = 1'b0; M_BREADY = 1'b0;
      chk("wrap_timeout", n < 100, 1);
      chk("wrap_count", popped.size(), 10);
      for (int i = 0; i < popped.size() && i < 10; i++) chk("wrap_order", popped[i], i);

      // Mid-operation asynchronous reset
      for (int i = 0; i < 3; i++) begin
         S_BVALID = 1'b1; S_BID = ID_W'(i + 9); S_BRESP = 2'b11;
         cyc();
      end
      S_BVALID = 1'b0;
      chk("pre_rst_count", count, 3);
      #1 ARESETn = 1'b0;
      #1;
      chk("midrst_bvalid", M_BVALID, 0);
      chk("midrst_count", count, 0);
      chk("midrst_bid", M_BID, 0);
      chk("midrst_sready", S_BREADY, 0);
      ARESETn = 1'b1;
      cyc();
      chk("midrst_sready_back", S_BREADY, 1);

`ifdef AXI_BRESP_ERR_CNT_EN
      chk("err_after_rst", err_count, 0);
      S_BVALID = 1'b1; S_BRESP = 2'b10; S_BID = 4'd1; cyc();
      S_BRESP = 2'b00; S_BID = 4'd2; cyc();
      S_BRESP = 2'b11; S_BID = 4'd3; cyc();
      S_BVALID = 1'b0;
      drain();
      chk("err_count_two", err_count, 2);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("err_cleared", err_count, 0);
`endif

      // Random traffic with varying source/sink pressure
      for (int i = 0; i < 2000; i++) begin
         int b;
         b = i / 400;
         S_BVALID = ($urandom_range(0, 4) < 1 + b % 4);
         S_BRESP  = 2'($urandom);
         S_BID    = ID_W'($urandom);
         M_BREADY = ($urandom_range(0, 4) < 4 - b % 4);
`ifdef AXI_BRESP_ERR_CNT_EN
         err_clr = ($urandom_range(0, 63) == 0);
`endif
         cyc();
      end
      S_BVALID = 1'b0;
`ifdef AXI_BRESP_ERR_CNT_EN
      err_clr = 1'b0;
`endif
      drain();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
